// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO feeding a UART frame serialiser. Bytes pushed with wr_en are
//   queued, then shifted out LSB first as start / data / optional parity /
//   stop bits. When the FIFO still holds data at the end of a stop bit, the
//   next frame starts on the following cycle, so there is no idle gap.
//
// Ports
//   clk        in   system clock, rising edge
//   nRst       in   asynchronous active-low reset
//   wr_en      in   push wr_data into the FIFO this cycle
//   wr_data    in   byte to transmit (DATA_W bits)
//   full       out  FIFO holds DEPTH entries; further writes are dropped
//   count      out  current FIFO occupancy
//   overflow   out  one-cycle pulse after a write was dropped because full
//   busy       out  a frame is on the line (start through last stop cycle)
//   frame_done out  one-cycle pulse on the final cycle of the last stop bit
//   tx_serial  out  serial line, idle high
//
// All outputs are registered. The line, busy and frame_done registers are
// loaded from the current FSM state, so they trail the state by one cycle:
// a pop at edge P puts the start bit on the line after edge P+1.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 1250,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     tx_serial
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [1:0] PAR_MODE = PARITY[1:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit of one data word: even mode gives XOR of the bits, odd mode
    // its complement.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d);
        logic p;
        p = ^d;
        if (PAR_MODE == 2'd2) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              full_q, full_d;
    logic              ovf_q;
    logic              push_s;
    logic              pop_s;

    // Serialiser state
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              line_s;
    logic              done_s;
    logic              bit_end_s;
    logic              last_data_s;
    logic              last_stop_s;
    logic              fifo_nonempty_s;

    // Registered outputs
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    assign full       = full_q;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign tx_serial  = tx_q;

    // full is the registered flag, so a write while full is dropped even if
    // the serialiser pops on the same edge.
    assign push_s          = wr_en & ~full_q;
    assign fifo_nonempty_s = (count_q != {(PTR_W+1){1'b0}});
    assign bit_end_s       = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign last_data_s     = (bit_idx_q == IDX_W'(DATA_W - 1));
    assign last_stop_s     = (stop_idx_q == 1'(STOP_BITS - 1));

    // FIFO next-state: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == (PTR_W+1)'(DEPTH));
    end

    // FIFO storage write port.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointer, occupancy and overflow registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= wr_en & full_q;
        end
    end

    // Serialiser next-state, line value and FIFO pop request.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = bit_end_s ? {CNT_W{1'b0}} : (clk_cnt_q + CNT_W'(1));
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        pop_s      = 1'b0;
        line_s     = 1'b1;
        done_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                line_s    = 1'b1;
                clk_cnt_d = {CNT_W{1'b0}};
                if (fifo_nonempty_s) begin
                    pop_s      = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    par_d      = parity_bit(mem_q[rd_ptr_q]);
                    bit_idx_d  = {IDX_W{1'b0}};
                    stop_idx_d = 1'b0;
                    state_d    = S_START;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_START: begin
                line_s = 1'b0;
                if (bit_end_s) begin
                    bit_idx_d = {IDX_W{1'b0}};
                    state_d   = S_DATA;
                end else begin
                    state_d   = S_START;
                end
            end
            S_DATA: begin
                line_s = shift_q[0];
                if (bit_end_s) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (last_data_s) begin
                        stop_idx_d = 1'b0;
                        state_d    = (PAR_MODE != 2'd0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d  = bit_idx_q + IDX_W'(1);
                        state_d    = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                line_s = par_q;
                if (bit_end_s) begin
                    stop_idx_d = 1'b0;
                    state_d    = S_STOP;
                end else begin
                    state_d    = S_PARITY;
                end
            end
            S_STOP: begin
                line_s = 1'b1;
                if (bit_end_s) begin
                    if (last_stop_s) begin
                        done_s = 1'b1;
                        // Chain straight into the next frame when data waits.
                        if (fifo_nonempty_s) begin
                            pop_s      = 1'b1;
                            shift_d    = mem_q[rd_ptr_q];
                            par_d      = parity_bit(mem_q[rd_ptr_q]);
                            bit_idx_d  = {IDX_W{1'b0}};
                            stop_idx_d = 1'b0;
                            state_d    = S_START;
                        end else begin
                            state_d    = S_IDLE;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                        state_d    = S_STOP;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                line_s    = 1'b1;
                clk_cnt_d = {CNT_W{1'b0}};
                state_d   = S_IDLE;
            end
        endcase
    end

    // Serialiser state registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= {CNT_W{1'b0}};
            bit_idx_q  <= {IDX_W{1'b0}};
            stop_idx_q <= 1'b0;
            shift_q    <= {DATA_W{1'b0}};
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
        end
    end

    // Output registers; reset forces the line idle at once, aborting a frame.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tx_q   <= line_s;
            busy_q <= (state_q != S_IDLE);
            done_q <= done_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (no parity / 1 stop, even parity /
// 1 stop, odd parity / 2 stops) share one stimulus stream. A frame-level model
// (queue of bytes, current frame as a bit list, cycle index into that frame)
// predicts every output each cycle; directed sections pin the model and the
// DUT against hand-computed line sequences.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int NI  = 3;

    logic       clk;
    logic       nRst;
    logic       wr_en;
    logic [7:0] wr_data;

    logic [NI-1:0] full_w, ovf_w, busy_w, done_w, tx_w;
    logic [2:0]    cnt_w [NI];

    uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) d0 (
        .clk(clk), .nRst(nRst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_w[0]), .count(cnt_w[0]), .overflow(ovf_w[0]),
        .busy(busy_w[0]), .frame_done(done_w[0]), .tx_serial(tx_w[0]));
    uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) d1 (
        .clk(clk), .nRst(nRst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_w[1]), .count(cnt_w[1]), .overflow(ovf_w[1]),
        .busy(busy_w[1]), .frame_done(done_w[1]), .tx_serial(tx_w[1]));
    uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) d2 (
        .clk(clk), .nRst(nRst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_w[2]), .count(cnt_w[2]), .overflow(ovf_w[2]),
        .busy(busy_w[2]), .frame_done(done_w[2]), .tx_serial(tx_w[2]));

    int tests = 0;
    int fails = 0;
    int par_m [NI] = '{0, 1, 2};
    int stp_m [NI] = '{1, 1, 2};
    int flen  [NI];

    // model state
    logic [7:0]  mq [NI][4];
    int          qh [NI];
    int          qn [NI];
    int          pos [NI];
    logic [15:0] fb [NI];
    logic        e_tx [NI];
    logic        e_busy [NI];
    logic        e_done [NI];
    logic        e_ovf [NI];
    logic        e_full [NI];
    int          e_cnt [NI];
    logic        chk_on = 1'b0;

    // activity counters
    int busy_cnt [NI];
    int done_cnt [NI];
    int falls    [NI];
    logic prev_busy [NI];

    task automatic chk(input int inst, input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL d%0d %s: got %0h, want %0h (t=%0t)", inst, nm, act, exp, $time);
        end
    endtask

    // Frame as a bit list, index 0 first on the line: start, data LSB first,
    // optional parity, then ones for the stop bits.
    function automatic logic [15:0] build_frame(input logic [7:0] d, input int par);
        logic [15:0] f;
        f    = 16'hFFFF;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) f[1+k] = d[k];
        if (par == 1) f[9] = ^d;
        if (par == 2) f[9] = ~^d;
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            qh[i] = 0; qn[i] = 0; pos[i] = -1;
            e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_done[i] = 1'b0;
            e_ovf[i] = 1'b0; e_full[i] = 1'b0; e_cnt[i] = 0;
        end
    endtask

    // One clock of the frame-level model for every instance.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            logic was_full;
            was_full = (qn[i] == 4);
            e_ovf[i] = wr_en && was_full;
            if (pos[i] >= 0) begin
                e_tx[i]   = fb[i][pos[i] / CPB];
                e_busy[i] = 1'b1;
                e_done[i] = (pos[i] == flen[i] - 1);
            end else begin
                e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_done[i] = 1'b0;
            end
            if (pos[i] < 0 || pos[i] == flen[i] - 1) begin
                if (qn[i] > 0) begin
                    fb[i]  = build_frame(mq[i][qh[i]], par_m[i]);
                    qh[i]  = (qh[i] + 1) % 4;
                    qn[i]  = qn[i] - 1;
                    pos[i] = 0;
                end else begin
                    pos[i] = -1;
                end
            end else begin
                pos[i] = pos[i] + 1;
            end
            if (wr_en && !was_full) begin
                mq[i][(qh[i] + qn[i]) % 4] = wr_data;
                qn[i] = qn[i] + 1;
            end
            e_cnt[i]  = qn[i];
            e_full[i] = (qn[i] == 4);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < NI; i++) flen[i] = (1 + 8 + (par_m[i] != 0 ? 1 : 0) + stp_m[i]) * CPB;
        model_reset();
        forever begin
            @(posedge clk or negedge nRst);
            if (!nRst) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int i = 0; i < NI; i++) begin
                    chk(i, "tx",    int'(tx_w[i]),   int'(e_tx[i]));
                    chk(i, "busy",  int'(busy_w[i]), int'(e_busy[i]));
                    chk(i, "done",  int'(done_w[i]), int'(e_done[i]));
                    chk(i, "ovf",   int'(ovf_w[i]),  int'(e_ovf[i]));
                    chk(i, "full",  int'(full_w[i]), int'(e_full[i]));
                    chk(i, "count", int'(cnt_w[i]),  e_cnt[i]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            busy_cnt[i] = 0; done_cnt[i] = 0; falls[i] = 0; prev_busy[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (busy_w[i]) busy_cnt[i]++;
                if (done_w[i]) done_cnt[i]++;
                if (prev_busy[i] && !busy_w[i]) falls[i]++;
                prev_busy[i] = busy_w[i];
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (k < 800 && !(busy_w == 3'b000 && cnt_w[0] == 3'd0 &&
                             cnt_w[1] == 3'd0 && cnt_w[2] == 3'd0)) begin
            @(negedge clk);
            k++;
        end
        chk(-1, "idle_wait_timeout", int'(k < 800), 1);
        @(negedge clk);
    endtask

    task automatic write1(input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    logic cap0 [60];
    logic cap1 [60];
    logic cap2 [60];
    int   b_busy [NI];
    int   b_done [NI];
    int   b_fall [NI];
    logic [15:0] fr;

    task automatic snap();
        for (int i = 0; i < NI; i++) begin
            b_busy[i] = busy_cnt[i]; b_done[i] = done_cnt[i]; b_fall[i] = falls[i];
        end
    endtask

    initial begin
        nRst = 1'b0; wr_en = 1'b0; wr_data = 8'h00;

        // model pinned against hand-derived frames
        fr = build_frame(8'hA5, 0);
        chk(-1, "model_frame_A5", int'(fr[9:0]), int'(10'b1101001010));
        fr = build_frame(8'h07, 1);
        chk(-1, "model_even_par_07", int'(fr[9]), 1);
        fr = build_frame(8'h07, 2);
        chk(-1, "model_odd_par_07", int'(fr[9]), 0);

        // 1: reset values
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        for (int i = 0; i < NI; i++) begin
            chk(i, "rst_tx", int'(tx_w[i]), 1);
            chk(i, "rst_busy", int'(busy_w[i]), 0);
            chk(i, "rst_count", int'(cnt_w[i]), 0);
            chk(i, "rst_full", int'(full_w[i]), 0);
            chk(i, "rst_pulses", int'({ovf_w[i], done_w[i]}), 0);
        end
        nRst = 1'b1;
        repeat (2) @(negedge clk);

        // 2: single byte A5, no parity, one stop bit
        snap();
        write1(8'hA5);
        cap0[0] = tx_w[0];
        for (int k = 1; k < 50; k++) begin @(negedge clk); cap0[k] = tx_w[0]; end
        chk(0, "a5_pre_start", int'(cap0[1]), 1);
        begin
            logic [9:0] seq;
            seq = 10'b1101001010;
            for (int b = 0; b < 10; b++)
                for (int j = 0; j < CPB; j++)
                    chk(0, $sformatf("a5_bit%0d_c%0d", b, j), int'(cap0[2 + b*CPB + j]), int'(seq[b]));
        end
        chk(0, "a5_after", int'(cap0[42]), 1);
        wait_idle();
        chk(0, "a5_busy_cycles", busy_cnt[0] - b_busy[0], 40);
        chk(0, "a5_done_pulses", done_cnt[0] - b_done[0], 1);

        // 3: parity bit for 8'h07, even vs odd
        snap();
        write1(8'h07);
        cap1[0] = tx_w[1]; cap2[0] = tx_w[2];
        for (int k = 1; k < 60; k++) begin
            @(negedge clk); cap1[k] = tx_w[1]; cap2[k] = tx_w[2];
        end
        for (int j = 0; j < CPB; j++) begin
            chk(1, "even_par_bit", int'(cap1[38 + j]), 1);
            chk(2, "odd_par_bit",  int'(cap2[38 + j]), 0);
        end
        wait_idle();
        chk(1, "par_frame_len", busy_cnt[1] - b_busy[1], 44);
        chk(2, "par2stop_frame_len", busy_cnt[2] - b_busy[2], 48);

        // 4 + 5: fill while a frame is on the line, then overflow with 8'hFF
        snap();
        write1(8'h3C);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk(-1, "burst_full", int'(full_w), int'(3'b111));
        chk(0, "burst_count", int'(cnt_w[0]), 4);
        wr_en = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        chk(-1, "ovf_pulse", int'(ovf_w), int'(3'b111));
        chk(0, "ovf_count", int'(cnt_w[0]), 4);
        @(negedge clk);
        chk(-1, "ovf_one_cycle", int'(ovf_w), 0);
        wait_idle();
        chk(0, "burst_done_pulses", done_cnt[0] - b_done[0], 5);
        chk(0, "burst_busy_cycles", busy_cnt[0] - b_busy[0], 200);
        chk(0, "burst_no_gap", falls[0] - b_fall[0], 1);
        chk(2, "burst_busy_cycles", busy_cnt[2] - b_busy[2], 240);

        // 6: reset during a data bit, queued byte must be discarded
        write1(8'h55);
        wr_en = 1'b1; wr_data = 8'h66;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (10) @(negedge clk);
        chk(0, "pre_rst_busy", int'(busy_w[0]), 1);
        @(posedge clk);
        #2 nRst = 1'b0;
        #1;
        chk(-1, "midrst_tx", int'(tx_w), int'(3'b111));
        chk(-1, "midrst_busy", int'(busy_w), 0);
        chk(0, "midrst_count", int'(cnt_w[0]), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 nRst = 1'b1;
        snap();
        repeat (80) @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk(i, "post_rst_silent", busy_cnt[i] - b_busy[i], 0);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 11) == 0);
            wr_data = 8'($urandom);
        end
        wr_en = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
